// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned words_per_pass(input int unsigned chain_len,
                                                 input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_loader.sv
// Serializes bitstream words into the ccff chain, with an optional second
// pass that compares returning tail bits against the resent stream.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | bs_ready high, waiting for a word
//   SHIFT | one bit per cycle onto ccff_head, chain advancing
//   DONE  | one-cycle completion pulse
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [0:WORD_W-1] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TOT_W = $clog2(2 * CHAIN_LEN + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [TOT_W-1:0] PASS_LEN  = TOT_W'(CHAIN_LEN);
  localparam logic [TOT_W-1:0] PASS1_END = TOT_W'(CHAIN_LEN - 1);
  localparam logic [TOT_W-1:0] PASS2_END = TOT_W'(2 * CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] WORD_END  = BIT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TOT_W-1:0]    tot_cnt_q, tot_cnt_d;
  logic                verify_q, verify_d;
  logic                err_q, err_d;
  logic                bs_ready_q, bs_ready_d;
  logic                shift_en_q, shift_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tot_cnt_d = tot_cnt_q;
    verify_d  = verify_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          verify_d  = verify;
          err_d     = 1'b0;
          bit_cnt_d = '0;
          tot_cnt_d = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bs_valid) begin
          // bs_data is ascending, so element i lands in shreg bit i
          for (int i = 0; i < WORD_W; i++) shreg_d[i] = bs_data[i];
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        tot_cnt_d = tot_cnt_q + 1'b1;
        // Pass-2 tail carries pass-1 bit k exactly when head carries pass-2 bit k
        if (tot_cnt_q >= PASS_LEN && ccff_tail != shreg_q[0]) err_d = 1'b1;
        if (tot_cnt_q == PASS1_END) begin
          state_d = verify_q ? ST_FETCH : ST_DONE;
        end else if (tot_cnt_q == PASS2_END) begin
          state_d = ST_DONE;
        end else if (bit_cnt_q == WORD_END) begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    bs_ready_d = (state_d == ST_FETCH);
    shift_en_d = (state_d == ST_SHIFT);
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tot_cnt_q  <= '0;
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
      bs_ready_q <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tot_cnt_q  <= tot_cnt_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
      bs_ready_q <= bs_ready_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ccff_head     = shreg_q[0];
  assign bs_ready      = bs_ready_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench: two loaders (40-bit and 36-bit chains) each driving a
// behavioural chain model, checked against hand-derived streams and latencies.
module tb_ccff_loader;
  import ccff_loader_pkg::*;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic       start40  = 1'b0;
  logic       start36  = 1'b0;
  logic       verify   = 1'b0;
  logic [0:7] bs_data  = '0;
  logic       bs_valid = 1'b0;

  logic rdy40, head40, en40, busy40, done40, err40, tail40;
  logic rdy36, head36, en36, busy36, done36, err36, tail36;

  logic [39:0] chain40 = '0;
  logic [35:0] chain36 = '0;

  logic [7:0] stream [0:9];
  bit         sel_g = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(40), .WORD_W(8)) u40 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start40), .verify(verify),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(rdy40),
    .ccff_head(head40), .ccff_tail(tail40), .ccff_shift_en(en40),
    .busy(busy40), .done(done40), .err(err40));

  ccff_loader #(.CHAIN_LEN(36), .WORD_W(8)) u36 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start36), .verify(verify),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(rdy36),
    .ccff_head(head36), .ccff_tail(tail36), .ccff_shift_en(en36),
    .busy(busy36), .done(done36), .err(err36));

  // Chain models: head enters bit 0, tail leaves the top bit
  always @(posedge prog_clk) if (en40) chain40 <= {chain40[38:0], head40};
  always @(posedge prog_clk) if (en36) chain36 <= {chain36[34:0], head36};
  assign tail40 = chain40[39];
  assign tail36 = chain36[35];

  logic rdy_s, head_s, en_s, busy_s, done_s, err_s;
  assign rdy_s  = sel_g ? rdy36  : rdy40;
  assign head_s = sel_g ? head36 : head40;
  assign en_s   = sel_g ? en36   : en40;
  assign busy_s = sel_g ? busy36 : busy40;
  assign done_s = sel_g ? done36 : done40;
  assign err_s  = sel_g ? err36  : err40;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bs_data[i] = w[i];
  endtask

  function automatic logic [63:0] exp_chain(input int len, input int base);
    logic [63:0] e;
    logic [7:0]  w;
    e = '0;
    for (int k = 0; k < len; k++) begin
      w = stream[base + k / 8];
      e[len - 1 - k] = w[k % 8];
    end
    return e;
  endfunction

  task automatic run_load(input bit sel, input bit ver, input int nwords,
                          input int stall_after, input int rst_at, input int mid_start_at,
                          output int cyc, output int hs, output int shifts,
                          output int err_first, output bit aborted);
    bit   fire, sh, got_done, head_hold;
    int   idx, stall, t;
    sel_g = sel;
    @(negedge prog_clk);
    verify = ver;
    if (sel) start36 = 1'b1; else start40 = 1'b1;
    bs_valid = 1'b1;
    set_word(stream[0]);
    idx = 0; cyc = 0; hs = 0; shifts = 0; err_first = -1; aborted = 1'b0;
    stall = 0; got_done = 1'b0; head_hold = 1'b0; t = 0;
    while (t < 400 && !got_done && !aborted) begin
      t++;
      fire = rdy_s && bs_valid;
      sh   = en_s;
      @(posedge prog_clk);
      cyc++;
      if (fire) begin hs++; idx++; end
      if (sh) shifts++;
      @(negedge prog_clk);
      start40 = 1'b0;
      start36 = 1'b0;
      if (cyc == mid_start_at) begin
        if (sel) start36 = 1'b1; else start40 = 1'b1;
      end
      if (idx < nwords) set_word(stream[idx]);
      if (err_s && err_first < 0) err_first = cyc;
      if (done_s) got_done = 1'b1;
      if (stall_after >= 0 && hs == stall_after && rdy_s && stall < 3) begin
        if (stall == 0) head_hold = head_s;
        else check_eq("stall_head", head_s, head_hold);
        check_eq("stall_en", en_s, 0);
        bs_valid = 1'b0;
        stall++;
      end else begin
        bs_valid = 1'b1;
      end
      if (cyc == rst_at) begin
        pReset = 1'b1;
        #1;
        check_eq("rst_outs", {head_s, en_s, rdy_s, busy_s, done_s, err_s}, 6'b0);
        aborted = 1'b1;
      end
    end
    bs_valid = 1'b0;
    if (!aborted) check_eq("done_seen", got_done, 1);
  endtask

  task automatic after_done();
    @(negedge prog_clk);
    check_eq("done_pulse", {done_s, busy_s}, 2'b00);
  endtask

  int  cyc, hs, shifts, err_first;
  bit  aborted;

  initial begin
    stream[0] = 8'h01; stream[1] = 8'h23; stream[2] = 8'h45;
    stream[3] = 8'h67; stream[4] = 8'h89;
    for (int i = 0; i < 5; i++) stream[5 + i] = stream[i];

    repeat (2) @(negedge prog_clk);
    check_eq("reset_40", {head40, en40, rdy40, busy40, done40, err40}, 6'b0);
    check_eq("reset_36", {head36, en36, rdy36, busy36, done36, err36}, 6'b0);
    pReset = 1'b0;

    // Plain load, 40-bit chain
    run_load(0, 0, 5, -1, -1, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t1_hs", hs, 5);
    check_eq("t1_shifts", shifts, 40);
    check_eq("t1_latency", cyc, 1 + words_per_pass(40, 8) + 40);
    check_eq("t1_err", err40, 0);
    check_eq("t1_chain", {24'b0, chain40}, exp_chain(40, 0));
    after_done();

    // Verify pass, identical resend
    run_load(0, 1, 10, -1, -1, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t2_hs", hs, 10);
    check_eq("t2_shifts", shifts, 80);
    check_eq("t2_latency", cyc, 91);
    check_eq("t2_err_first", err_first, -1);
    check_eq("t2_chain", {24'b0, chain40}, exp_chain(40, 5));
    after_done();

    // Verify pass with pass-2 word 3 bit 2 flipped; start mid-run must be ignored
    stream[7] = stream[7] ^ 8'h04;
    run_load(0, 1, 10, -1, -1, 75, cyc, hs, shifts, err_first, aborted);
    check_eq("t3_err_first", err_first, 68);
    check_eq("t3_latency", cyc, 91);
    check_eq("t3_err_done", err40, 1);
    check_eq("t3_chain", {24'b0, chain40}, exp_chain(40, 5));
    after_done();
    check_eq("t3_err_sticky", err40, 1);

    // Next start clears err
    stream[7] = stream[2];
    run_load(0, 0, 5, -1, -1, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t4_err_cleared", err_first, -1);
    check_eq("t4_latency", cyc, 46);
    check_eq("t4_chain", {24'b0, chain40}, exp_chain(40, 0));
    after_done();

    // 36-bit chain: surplus top nibble of the last word never shifted
    stream[4] = 8'hF9;
    run_load(1, 0, 5, -1, -1, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t5_hs", hs, words_per_pass(36, 8));
    check_eq("t5_shifts", shifts, 36);
    check_eq("t5_latency", cyc, 42);
    check_eq("t5_chain", {28'b0, chain36}, exp_chain(36, 0));
    after_done();
    stream[4] = 8'h89;

    // Stall three FETCH cycles after word 2
    chain40 = '0;
    run_load(0, 0, 5, 2, -1, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t6_latency", cyc, 49);
    check_eq("t6_shifts", shifts, 40);
    check_eq("t6_chain", {24'b0, chain40}, exp_chain(40, 0));
    after_done();

    // Reset during SHIFT of word 3, then a fresh load with a stray mid-run start
    run_load(0, 0, 5, -1, 21, -1, cyc, hs, shifts, err_first, aborted);
    check_eq("t7_aborted", aborted, 1);
    check_eq("t7_hs", hs, 3);
    @(negedge prog_clk);
    check_eq("t7_no_done", {done40, busy40}, 2'b00);
    pReset = 1'b0;
    @(negedge prog_clk);
    check_eq("t7_idle", {done40, busy40, rdy40, en40}, 4'b0);
    run_load(0, 0, 5, -1, -1, 10, cyc, hs, shifts, err_first, aborted);
    check_eq("t7_latency", cyc, 46);
    check_eq("t7_shifts", shifts, 40);
    check_eq("t7_chain", {24'b0, chain40}, exp_chain(40, 0));
    after_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
